pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
- Parametrised elastic pipeline register that replaces the fixed always-load inter-stage registers between fetch, decode, execute, mem and write_back.
- Holds up to DEPTH entries of WIDTH-bit payload behind a valid/ready handshake, so a stalled downstream stage back-pressures upstream without losing data.
- Supports a synchronous flush for branch/trap redirects; one instance per stage boundary, with the payload being that stage's concatenated bundle (npc, ir, cw, operands, dr, cc).

Parameters:
- WIDTH, 16, payload width in bits (default one lc3b_word); legal range WIDTH >= 1.
- DEPTH, 2, number of storage entries; legal range DEPTH >= 1, not required to be a power of two.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all held and incoming entries.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  buffer can accept; a transfer occurs when in_valid && in_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes; a transfer occurs when out_valid && out_ready.
- out_data  out  WIDTH  head entry payload.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - count = 0; read and write pointers = 0.
  - out_valid = 0; in_ready = 1; out_data = 0.
  - Storage contents are don't-care.
- Signal derivation:
  - in_ready = (count < DEPTH), decoded from registered count only. There is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
  - out_data = storage[rd_ptr] when count != 0, else forced to 0.
- Latency: data accepted at edge N is visible on out_data/out_valid after edge N (one cycle). There is no same-cycle bypass.
- Push: on accept, write storage[wr_ptr] and advance wr_ptr, wrapping from DEPTH-1 to 0.
- Pop: on consume, advance rd_ptr with the same wrap.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When count == DEPTH, a push cannot occur because in_ready = 0. Ready returns in the cycle after the pop.
  - When count == 0, a pop cannot occur.
- Full throughput: with DEPTH >= 2 and out_ready held high, one transfer per cycle is sustained. With DEPTH = 1, throughput is one transfer per two cycles (ready depends only on registered count).
- Flush (synchronous, highest priority):
  - At the next edge, count = 0 and both pointers = 0.
  - Any push or pop in the flush cycle is dropped or ignored.
  - In the following cycle, out_valid = 0 and in_ready = 1.
- Reset mid-operation: all state clears immediately; in-flight entries are lost.
- Width rules:
  - count saturates by construction, never exceeding DEPTH.
  - Pointer width is max(1, $clog2(DEPTH)).
  - Assertions:
    - count <= DEPTH.
    - Storage is never written while full.
    - out_data is stable while out_valid && !out_ready.

Decomposition:
- lc3b_types gains:
  - Stage-bundle typedefs (lc3b_fd_bundle, lc3b_dx_bundle, lc3b_xm_bundle, lc3b_mw_bundle) so callers size WIDTH with $bits().
  - A constant PIPE_BUF_DEPTH = 2.
- Storage is an inline register array. No sub-module is needed; the pointer/count logic fits in one always_ff plus one always_comb.

Test Plan:
- Reset and idle: assert reset_n = 0 mid-cycle -> out_valid = 0, in_ready = 1, count = 0, out_data = 16'h0000 immediately without a clock edge.
- Streaming: DEPTH = 2, out_ready = 1, push 16'h1000, 16'h1002, 16'h1004 on consecutive cycles -> the same values appear on out_data one cycle later each, count stays at 1, no bubbles.
- Back-pressure and full:
  - Hold out_ready = 0 and push 16'hA5A5, then 16'h5A5A -> count = 2, in_ready = 0; a third in_valid with 16'hFFFF is not accepted.
  - Raise out_ready -> output order is A5A5, 5A5A; in_ready returns 1 one cycle after the first pop.
- Wrap-around: DEPTH = 3, perform 7 push/pop pairs with payloads 1..7 under random out_ready -> output order is 1..7 with no duplicates or loss, and the pointers wrap at 2.
- Flush priority: count = 2 and in_valid = 1 with 16'hBEEF in the same cycle as flush = 1 -> next cycle count = 0 and out_valid = 0; 16'hBEEF never emerges.
- DEPTH = 1, WIDTH = 32, continuous in_valid and out_ready -> transfers occur on alternate cycles, and out_data matches the 32-bit payloads in order.

Source files
------------

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared LC-3b pipeline types: stage-boundary bundles sized with $bits() by the
// elastic buffers placed between stages, plus the default buffer depth.
package pipe_stage_buffer_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [2:0]  lc3b_nzp;

    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [3:0] alu_op;
        logic [1:0] regfile_sel;
        logic [4:0] rsvd;
    } lc3b_control_word;

    typedef struct packed {
        lc3b_word npc;
        lc3b_word ir;
    } lc3b_fd_bundle;

    typedef struct packed {
        lc3b_word         npc;
        lc3b_word         ir;
        lc3b_control_word cw;
        lc3b_word         sr1_val;
        lc3b_word         sr2_val;
        lc3b_reg          dr;
    } lc3b_dx_bundle;

    typedef struct packed {
        lc3b_word         npc;
        lc3b_word         ir;
        lc3b_control_word cw;
        lc3b_word         alu_out;
        lc3b_word         sr2_val;
        lc3b_reg          dr;
    } lc3b_xm_bundle;

    typedef struct packed {
        lc3b_word         npc;
        lc3b_word         ir;
        lc3b_control_word cw;
        lc3b_word         alu_out;
        lc3b_word         mem_rdata;
        lc3b_reg          dr;
        lc3b_nzp          cc;
    } lc3b_mw_bundle;

    localparam int PIPE_BUF_DEPTH = 2;

    // A single-entry buffer still needs a 1-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// Elastic valid/ready pipeline register with DEPTH entries and a synchronous flush.
// in_ready depends only on registered occupancy, so no out_ready->in_ready path exists.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = PIPE_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: out_data is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (!reset_n)
        count_q <= CW'(DEPTH));

    a_no_write_full : assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !flush && count_q == CW'(DEPTH)));

    a_hold_stable : assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Drives three buffer configurations (D2/W16, D3/W16, D1/W32) with shared stimulus and
// checks each against its own queue model of the valid/ready/flush contract.
module tb_pipe_stage_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        in_ready_a, out_valid_a;
    logic [15:0] out_data_a;
    logic [1:0]  count_a;
    logic        in_ready_b, out_valid_b;
    logic [15:0] out_data_b;
    logic [1:0]  count_b;
    logic        in_ready_c, out_valid_c;
    logic [31:0] out_data_c;
    logic [0:0]  count_c;

    int vectors     = 0;
    int miscompares = 0;

    int          dep [3] = '{2, 3, 1};
    logic [31:0] msk [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
    logic [31:0] mq  [3][$];

    always #5 clk = ~clk;

    pipe_stage_buffer #(.WIDTH(16), .DEPTH(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data[15:0]),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .count(count_a));

    pipe_stage_buffer #(.WIDTH(16), .DEPTH(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data[15:0]),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .count(count_b));

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .count(count_c));

    task automatic check_all(input string ph);
        logic        ov [3];
        logic        ir [3];
        logic [31:0] od [3];
        logic [31:0] oc [3];
        logic [31:0] ed, ec;
        logic        ev, er;
        ov[0] = out_valid_a; ir[0] = in_ready_a; od[0] = 32'(out_data_a); oc[0] = 32'(count_a);
        ov[1] = out_valid_b; ir[1] = in_ready_b; od[1] = 32'(out_data_b); oc[1] = 32'(count_b);
        ov[2] = out_valid_c; ir[2] = in_ready_c; od[2] = out_data_c;      oc[2] = 32'(count_c);
        for (int k = 0; k < 3; k++) begin
            ec = 32'(mq[k].size());
            ev = (mq[k].size() != 0);
            er = (mq[k].size() < dep[k]);
            ed = ev ? mq[k][0] : 32'h0;
            vectors++;
            assert (ov[k] === ev) else begin
                miscompares++;
                $error("FAIL %s out_valid D%0d observed=%b expected=%b", ph, dep[k], ov[k], ev);
            end
            vectors++;
            assert (ir[k] === er) else begin
                miscompares++;
                $error("FAIL %s in_ready D%0d observed=%b expected=%b", ph, dep[k], ir[k], er);
            end
            vectors++;
            assert (oc[k] === ec) else begin
                miscompares++;
                $error("FAIL %s count D%0d observed=%0d expected=%0d", ph, dep[k], oc[k], ec);
            end
            vectors++;
            assert (od[k] === ed) else begin
                miscompares++;
                $error("FAIL %s out_data D%0d observed=%h expected=%h", ph, dep[k], od[k], ed);
            end
        end
    endtask

    // One clock of stimulus; the model decides transfers from the pre-edge occupancy.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                        input logic fl, input string ph);
        bit do_push, do_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (fl) begin
                mq[k].delete();
            end else begin
                do_pop  = ordy && (mq[k].size() != 0);
                do_push = iv && (mq[k].size() < dep[k]);
                if (do_pop)  void'(mq[k].pop_front());
                if (do_push) mq[k].push_back(d & msk[k]);
            end
        end
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc;
        int          guard;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #7;
        check_all("reset_idle");
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, "idle");

        // Streaming with out_ready held high
        step(1'b1, 32'h1000, 1'b1, 1'b0, "stream");
        step(1'b1, 32'h1002, 1'b1, 1'b0, "stream");
        step(1'b1, 32'h1004, 1'b1, 1'b0, "stream");
        step(1'b0, 32'h0,    1'b1, 1'b0, "stream_drain");
        step(1'b0, 32'h0,    1'b1, 1'b0, "stream_drain");

        // Back-pressure until full, then drain
        step(1'b1, 32'hA5A5, 1'b0, 1'b0, "bp_fill");
        step(1'b1, 32'h5A5A, 1'b0, 1'b0, "bp_fill");
        step(1'b1, 32'hFFFF, 1'b0, 1'b0, "bp_full");
        step(1'b0, 32'h0,    1'b1, 1'b0, "bp_pop");
        step(1'b0, 32'h0,    1'b1, 1'b0, "bp_pop");
        step(1'b0, 32'h0,    1'b1, 1'b0, "bp_pop");
        step(1'b0, 32'h0,    1'b1, 1'b0, "bp_pop");

        // Wrap-around: payloads 1..7 under random out_ready
        for (int i = 1; i <= 7; i++) begin
            guard = 0;
            do begin
                acc = (mq[1].size() < dep[1]);
                step(1'b1, 32'(i), 1'($urandom_range(0, 1)), 1'b0, "wrap");
                guard++;
            end while (!acc && guard < 64);
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, "wrap_drain");

        // Flush overrides a simultaneous push
        step(1'b1, 32'h0011, 1'b0, 1'b0, "flush_fill");
        step(1'b1, 32'h0022, 1'b0, 1'b0, "flush_fill");
        step(1'b1, 32'hBEEF, 1'b1, 1'b1, "flush");
        step(1'b0, 32'h0,    1'b1, 1'b0, "post_flush");

        // Continuous traffic, 32-bit payloads
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hC0DE_0000 + 32'(i * 32'h0101_0001), 1'b1, 1'b0, "d1_stream");
        end
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, "d1_drain");

        // Asynchronous reset between edges with entries held
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, "pre_reset");
        step(1'b1, 32'h9ABC_DEF0, 1'b0, 1'b0, "pre_reset");
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) mq[k].delete();
        check_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0), "random");
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, "final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
